mig_cmd_issue: RTL

//  Drains the sync command FIFO (sfifo) and issues each entry on the MIG UI
//  (app_* command and write-data ports), one single-beat command at a time.
//  It sits directly downstream of sfifo: it watches rqempty, samples rdata and pulses rnext.
//  It limits outstanding reads and returns read data one cycle after MIG delivers it.

---
 rtl/mig_cmd_issue.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mig_cmd_issue.sv
// Pops single-beat commands from the sync command FIFO and issues them on the MIG UI.
// Limits outstanding reads and returns read beats one cycle after MIG delivers them.
module mig_cmd_issue #(
    parameter int ADDRW  = 28,
    parameter int DATAW  = 128,
    parameter int MASKW  = DATAW / 8,
    parameter int MAX_RD = 4,
    parameter int CNTW   = 3,
    parameter int FW     = 1 + ADDRW + DATAW + MASKW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init_calib_complete,
    input  logic             fifo_rqempty,
    input  logic [FW-1:0]    fifo_rdata,
    output logic             fifo_rnext,
    output logic             app_en,
    output logic [2:0]       app_cmd,
    output logic [ADDRW-1:0] app_addr,
    input  logic             app_rdy,
    output logic             app_wdf_wren,
    output logic             app_wdf_end,
    output logic [DATAW-1:0] app_wdf_data,
    output logic [MASKW-1:0] app_wdf_mask,
    input  logic             app_wdf_rdy,
    input  logic             app_rd_data_valid,
    input  logic [DATAW-1:0] app_rd_data,
    output logic             rd_valid,
    output logic [DATAW-1:0] rd_data,
    output logic             busy,
    output logic             rd_err
);

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state_reg;
    logic              cmd_done_reg;
    logic              wdf_done_reg;
    logic [CNTW-1:0]   rd_cnt_reg;

    logic entry_is_rd;
    logic can_pop;
    logic cmd_acc;
    logic wdf_acc;
    logic rd_accept;

    assign entry_is_rd = fifo_rdata[FW-1];
    assign can_pop     = init_calib_complete && !fifo_rqempty &&
                         (!entry_is_rd || (rd_cnt_reg < CNTW'(MAX_RD)));
    assign cmd_acc     = app_en && app_rdy;
    assign wdf_acc     = app_wdf_wren && app_wdf_rdy;
    assign rd_accept   = cmd_acc && (app_cmd == CMD_RD);
    assign busy        = (state_reg != IDLE) || (rd_cnt_reg != '0);

    // The app_* address/data registers double as the holding register: the FIFO head
    // changes right after the pop, so the entry is captured in the same cycle as rnext.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            fifo_rnext   <= 1'b0;
            app_en       <= 1'b0;
            app_cmd      <= CMD_WR;
            app_addr     <= '0;
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_mask <= '0;
            cmd_done_reg <= 1'b0;
            wdf_done_reg <= 1'b0;
        end else begin
            fifo_rnext <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (can_pop) begin
                        fifo_rnext   <= 1'b1;
                        app_cmd      <= entry_is_rd ? CMD_RD : CMD_WR;
                        app_addr     <= fifo_rdata[MASKW+DATAW +: ADDRW];
                        app_wdf_data <= fifo_rdata[MASKW +: DATAW];
                        app_wdf_mask <= fifo_rdata[MASKW-1:0];
                        cmd_done_reg <= 1'b0;
                        wdf_done_reg <= entry_is_rd;
                        state_reg    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (fifo_rnext) begin
                        // First ISSUE cycle: raise the request strobes.
                        app_en       <= 1'b1;
                        app_wdf_wren <= !wdf_done_reg;
                        app_wdf_end  <= !wdf_done_reg;
                    end else begin
                        if (cmd_acc) begin
                            app_en       <= 1'b0;
                            cmd_done_reg <= 1'b1;
                        end
                        if (wdf_acc) begin
                            app_wdf_wren <= 1'b0;
                            app_wdf_end  <= 1'b0;
                            wdf_done_reg <= 1'b1;
                        end
                        if ((cmd_done_reg || cmd_acc) && (wdf_done_reg || wdf_acc))
                            state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Outstanding-read accounting; a beat with nothing outstanding is flagged, not wrapped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_reg <= '0;
            rd_err     <= 1'b0;
        end else begin
            if (app_rd_data_valid && (rd_cnt_reg == '0))
                rd_err <= 1'b1;
            unique case ({rd_accept, app_rd_data_valid})
                2'b10:   rd_cnt_reg <= rd_cnt_reg + CNTW'(1);
                2'b01:   if (rd_cnt_reg != '0) rd_cnt_reg <= rd_cnt_reg - CNTW'(1);
                default: rd_cnt_reg <= rd_cnt_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= app_rd_data_valid;
            rd_data  <= app_rd_data;
        end
    end

endmodule
